// File: rtl/fp_add_issue_scheduler_if.sv
// rtl/fp_add_issue_scheduler_if.sv - request/feedback/issue bus between requesters, scheduler and adder
interface fp_add_issue_scheduler_if;
  logic        new_valid;
  logic        new_ready;
  logic [35:0] new_cout;
  logic [35:0] new_zout;
  logic [3:0]  new_opcode;
  logic [7:0]  new_tag;

  logic        fb_valid;
  logic        fb_ready;
  logic [35:0] fb_cout;
  logic [35:0] fb_zout;
  logic [3:0]  fb_opcode;
  logic [7:0]  fb_tag;

  logic        issue_idle;
  logic [35:0] issue_cout;
  logic [35:0] issue_zout;
  logic [3:0]  issue_opcode;
  logic [7:0]  issue_tag;
  logic        issue_src;

  modport master (
    output new_valid, new_cout, new_zout, new_opcode, new_tag,
    output fb_valid, fb_cout, fb_zout, fb_opcode, fb_tag,
    input  new_ready, fb_ready,
    input  issue_idle, issue_cout, issue_zout, issue_opcode, issue_tag, issue_src
  );

  modport slave (
    input  new_valid, new_cout, new_zout, new_opcode, new_tag,
    input  fb_valid, fb_cout, fb_zout, fb_opcode, fb_tag,
    output new_ready, fb_ready,
    output issue_idle, issue_cout, issue_zout, issue_opcode, issue_tag, issue_src
  );
endinterface

// File: rtl/fp_add_issue_scheduler.sv
// rtl/fp_add_issue_scheduler.sv - credit-limited feedback-priority issue arbiter for the FP adder
module fp_add_issue_scheduler #(
  parameter int unsigned MAX_OUT      = 8,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  fp_add_issue_scheduler_if.slave    bus,
  input  logic                       done_valid,
  input  logic                       flush_req,
  output logic                       flush_done,
  output logic [3:0]                 credits,
  output logic                       busy,
  output logic                       err_credit
);

  localparam logic [3:0] MAX_C    = 4'(MAX_OUT);
  localparam logic [3:0] STARVE_C = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  credits_q, credits_d;
  logic [3:0]  starve_q, starve_d;
  logic        err_q, err_d;
  logic        busy_q;
  logic        flush_done_q;

  logic        issue_idle_q, issue_idle_d;
  logic [35:0] issue_cout_q, issue_cout_d;
  logic [35:0] issue_zout_q, issue_zout_d;
  logic [3:0]  issue_opcode_q, issue_opcode_d;
  logic [7:0]  issue_tag_q, issue_tag_d;
  logic        issue_src_q, issue_src_d;

  logic        has_credit;
  logic        starved;
  logic        new_xfer;
  logic        fb_xfer;
  logic        xfer;

  // Readies derive only from state, credits, the other port's valid and starvation,
  // so at most one port can transfer per cycle.
  always_comb begin
    has_credit   = (credits_q != 4'd0);
    starved      = (starve_q == STARVE_C);
    bus.fb_ready = (state_q != DONE) && has_credit &&
                   !(bus.new_valid && starved && (state_q == RUN));
    bus.new_ready = (state_q == RUN) && has_credit && (!bus.fb_valid || starved);
    new_xfer     = bus.new_valid && bus.new_ready;
    fb_xfer      = bus.fb_valid && bus.fb_ready;
    xfer         = new_xfer || fb_xfer;
  end

  // Next-state for FSM, credits, starvation counter and the issue register.
  always_comb begin
    state_d        = state_q;
    credits_d      = credits_q;
    err_d          = err_q;
    starve_d       = starve_q;
    issue_idle_d   = !xfer;
    issue_cout_d   = issue_cout_q;
    issue_zout_d   = issue_zout_q;
    issue_opcode_d = issue_opcode_q;
    issue_tag_d    = issue_tag_q;
    issue_src_d    = issue_src_q;

    unique case (state_q)
      RUN:     if (flush_req) state_d = DRAIN;
      DRAIN:   if ((credits_q == MAX_C) && !bus.fb_valid) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase

    // A retirement with nothing outstanding is dropped and flagged.
    if (xfer && !done_valid) begin
      credits_d = credits_q - 4'd1;
    end else if (!xfer && done_valid) begin
      if (credits_q == MAX_C) err_d = 1'b1;
      else                    credits_d = credits_q + 4'd1;
    end

    if (!bus.new_valid || new_xfer) begin
      starve_d = 4'd0;
    end else if (fb_xfer && (state_q == RUN) && !starved) begin
      starve_d = starve_q + 4'd1;
    end

    if (new_xfer) begin
      issue_cout_d   = bus.new_cout;
      issue_zout_d   = bus.new_zout;
      issue_opcode_d = bus.new_opcode;
      issue_tag_d    = bus.new_tag;
      issue_src_d    = 1'b0;
    end else if (fb_xfer) begin
      issue_cout_d   = bus.fb_cout;
      issue_zout_d   = bus.fb_zout;
      issue_opcode_d = bus.fb_opcode;
      issue_tag_d    = bus.fb_tag;
      issue_src_d    = 1'b1;
    end
  end

  // State, credit and issue registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= RUN;
      credits_q      <= MAX_C;
      starve_q       <= 4'd0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
      flush_done_q   <= 1'b0;
      issue_idle_q   <= 1'b1;
      issue_cout_q   <= 36'd0;
      issue_zout_q   <= 36'd0;
      issue_opcode_q <= 4'd0;
      issue_tag_q    <= 8'd0;
      issue_src_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      credits_q      <= credits_d;
      starve_q       <= starve_d;
      err_q          <= err_d;
      busy_q         <= (credits_d != MAX_C);
      flush_done_q   <= (state_d == DONE);
      issue_idle_q   <= issue_idle_d;
      issue_cout_q   <= issue_cout_d;
      issue_zout_q   <= issue_zout_d;
      issue_opcode_q <= issue_opcode_d;
      issue_tag_q    <= issue_tag_d;
      issue_src_q    <= issue_src_d;
    end
  end

  assign bus.issue_idle   = issue_idle_q;
  assign bus.issue_cout   = issue_cout_q;
  assign bus.issue_zout   = issue_zout_q;
  assign bus.issue_opcode = issue_opcode_q;
  assign bus.issue_tag    = issue_tag_q;
  assign bus.issue_src    = issue_src_q;
  assign credits          = credits_q;
  assign busy             = busy_q;
  assign err_credit       = err_q;
  assign flush_done       = flush_done_q;

endmodule

// File: tb/tb_fp_add_issue_scheduler.sv
// tb/tb_fp_add_issue_scheduler.sv - scoreboard bench for fp_add_issue_scheduler
module tb_fp_add_issue_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       done_valid;
  logic       flush_req;
  logic       flush_done;
  logic [3:0] credits;
  logic       busy;
  logic       err_credit;

  fp_add_issue_scheduler_if bus ();

  fp_add_issue_scheduler #(.MAX_OUT(8), .STARVE_LIMIT(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .done_valid (done_valid),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .credits    (credits),
    .busy       (busy),
    .err_credit (err_credit)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        src;
    logic [7:0]  tag;
    logic [3:0]  op;
    logic [35:0] c;
    logic [35:0] z;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] tag_ctr = 8'h20;

  localparam int NONE = 0;
  localparam int NEW  = 1;
  localparam int FB   = 2;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic refresh();
    tag_ctr        = tag_ctr + 8'd1;
    bus.new_tag    = tag_ctr;
    bus.new_opcode = 4'(tag_ctr % 12);
    bus.new_cout   = {4'($urandom), 32'($urandom)};
    bus.new_zout   = {4'($urandom), 32'($urandom)};
    bus.fb_tag     = tag_ctr ^ 8'h80;
    bus.fb_opcode  = 4'((tag_ctr + 8'd5) % 12);
    bus.fb_cout    = {4'($urandom), 32'($urandom)};
    bus.fb_zout    = {4'($urandom), 32'($urandom)};
  endtask

  task automatic cycle(input int kind);
    exp_t e;
    #1;
    chk("new_xfer", 64'(bus.new_valid && bus.new_ready), 64'(kind == NEW));
    chk("fb_xfer",  64'(bus.fb_valid && bus.fb_ready),   64'(kind == FB));
    if (kind == NEW) begin
      e = '{1'b0, bus.new_tag, bus.new_opcode, bus.new_cout, bus.new_zout};
      exp_q.push_back(e);
    end else if (kind == FB) begin
      e = '{1'b1, bus.fb_tag, bus.fb_opcode, bus.fb_cout, bus.fb_zout};
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    chk("issue_idle", 64'(bus.issue_idle), 64'(exp_q.size() == 0));
    if (!bus.issue_idle && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("issue_src",    64'(bus.issue_src),    64'(e.src));
      chk("issue_tag",    64'(bus.issue_tag),    64'(e.tag));
      chk("issue_opcode", 64'(bus.issue_opcode), 64'(e.op));
      chk("issue_cout",   64'(bus.issue_cout),   64'(e.c));
      chk("issue_zout",   64'(bus.issue_zout),   64'(e.z));
    end
    exp_q.delete();
    refresh();
  endtask

  initial begin
    reset = 1'b1; done_valid = 1'b0; flush_req = 1'b0;
    bus.new_valid = 1'b0; bus.fb_valid = 1'b0;
    refresh();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_idle",   64'(bus.issue_idle), 64'd1);
    chk("rst_tag",    64'(bus.issue_tag),  64'd0);
    chk("rst_src",    64'(bus.issue_src),  64'd0);
    chk("rst_cout",   64'(bus.issue_cout), 64'd0);
    chk("rst_cred",   64'(credits),        64'd8);
    chk("rst_busy",   64'(busy),           64'd0);
    chk("rst_err",    64'(err_credit),     64'd0);
    chk("rst_fdone",  64'(flush_done),     64'd0);
    reset = 1'b0;

    // First new transfer, tag 0x11 opcode 0.
    bus.new_valid = 1'b1; bus.new_tag = 8'h11; bus.new_opcode = 4'd0;
    cycle(NEW);
    chk("first_cred", 64'(credits), 64'd7);
    chk("first_busy", 64'(busy),    64'd1);
    bus.new_valid = 1'b0; done_valid = 1'b1;
    cycle(NONE);
    done_valid = 1'b0;
    chk("ret_cred", 64'(credits), 64'd8);
    chk("ret_busy", 64'(busy),    64'd0);

    // Contention: feedback wins three times then new wins once.
    bus.new_valid = 1'b1; bus.fb_valid = 1'b1; done_valid = 1'b1;
    for (int i = 0; i < 10; i++) cycle(((i % 4) == 3) ? NEW : FB);
    bus.new_valid = 1'b0; bus.fb_valid = 1'b0; done_valid = 1'b0;
    cycle(NONE);
    chk("starve_cred", 64'(credits),    64'd8);
    chk("starve_err",  64'(err_credit), 64'd0);

    // Credit exhaustion and single-credit recovery.
    bus.new_valid = 1'b1;
    for (int i = 0; i < 8; i++) cycle(NEW);
    chk("exh_cred", 64'(credits), 64'd0);
    bus.fb_valid = 1'b1;
    cycle(NONE);
    done_valid = 1'b1;
    cycle(NONE);
    done_valid = 1'b0;
    chk("one_cred", 64'(credits), 64'd1);
    cycle(FB);
    chk("zero_again", 64'(credits), 64'd0);
    cycle(NONE);
    bus.new_valid = 1'b0; bus.fb_valid = 1'b0; done_valid = 1'b1;
    for (int i = 0; i < 8; i++) cycle(NONE);
    done_valid = 1'b0;
    chk("refill_cred", 64'(credits), 64'd8);
    chk("refill_err",  64'(err_credit), 64'd0);

    // Overflow: retirement with all credits home.
    done_valid = 1'b1;
    cycle(NONE);
    done_valid = 1'b0;
    chk("ovf_err",  64'(err_credit), 64'd1);
    chk("ovf_cred", 64'(credits),    64'd8);
    cycle(NONE);
    cycle(NONE);
    chk("ovf_sticky", 64'(err_credit), 64'd1);

    // Drain: new blocked, completes after outstanding ops retire.
    bus.new_valid = 1'b1;
    for (int i = 0; i < 3; i++) cycle(NEW);
    chk("pre_flush_cred", 64'(credits), 64'd5);
    bus.new_valid = 1'b0; flush_req = 1'b1;
    cycle(NONE);
    flush_req = 1'b0; bus.new_valid = 1'b1;
    chk("drain_fdone0", 64'(flush_done), 64'd0);
    #1;
    chk("drain_fb_ready", 64'(bus.fb_ready), 64'd1);
    done_valid = 1'b1;
    for (int i = 0; i < 3; i++) cycle(NONE);
    done_valid = 1'b0;
    chk("drain_cred",   64'(credits),    64'd8);
    chk("drain_fdone1", 64'(flush_done), 64'd0);
    cycle(NONE);
    chk("done_pulse", 64'(flush_done), 64'd1);
    cycle(NONE);
    chk("done_clear", 64'(flush_done), 64'd0);
    cycle(NEW);
    chk("post_flush_cred", 64'(credits), 64'd7);
    bus.new_valid = 1'b0; done_valid = 1'b1;
    cycle(NONE);
    done_valid = 1'b0;

    // Reset in the middle of a drain with five credits.
    bus.new_valid = 1'b1;
    for (int i = 0; i < 3; i++) cycle(NEW);
    bus.new_valid = 1'b0; flush_req = 1'b1;
    cycle(NONE);
    flush_req = 1'b0;
    cycle(NONE);
    chk("mid_drain_cred", 64'(credits), 64'd5);
    reset = 1'b1;
    cycle(NONE);
    reset = 1'b0;
    chk("rdrain_cred",  64'(credits),        64'd8);
    chk("rdrain_idle",  64'(bus.issue_idle), 64'd1);
    chk("rdrain_fdone", 64'(flush_done),     64'd0);
    chk("rdrain_err",   64'(err_credit),     64'd0);
    bus.new_valid = 1'b1;
    cycle(NEW);
    bus.new_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
